// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one-at-a-time word fetches to instruction
// memory, buffers responses in a small prefetch FIFO and feeds the decode
// stage through a stall-aware output register. A taken branch flushes the
// FIFO and discards any response still in flight, then restarts at the target.
//
// state  | meaning
// S_IDLE | no request outstanding; issue when FIFO space allows
// S_WAIT | request outstanding; req/addr held until ack
module fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [31:0] NOP_INST = 32'h3C00_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_target_i,
    input  logic        stall_i,
    output logic [31:0] inst_o,
    output logic [15:0] pc_value_o,
    output logic        valid_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_t;

    state_t             r_state;
    logic               r_req;
    logic [15:0]        r_addr;
    logic [15:0]        r_fa;
    logic               r_drop;
    logic [47:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic [31:0]        r_inst;
    logic [15:0]        r_pc;
    logic               r_valid;

    logic               w_xfer;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_space;

    // A transfer only counts while a request is actually outstanding; a
    // redirect kills both the push and the pop of the current cycle.
    always_comb begin
        w_xfer     = r_req & imem_ack_i;
        w_push     = w_xfer & ~r_drop & ~br_taken_i;
        w_pop      = ~br_taken_i & ~stall_i & (r_count != '0);
        w_cnt_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_space    = (w_cnt_next < DEPTH_C);
    end

    // Request FSM: owns req/addr, the fetch pointer and the drop flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_fa    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (br_taken_i) begin
                        r_fa <= br_target_i;
                    end else if (w_space) begin
                        r_req   <= 1'b1;
                        r_addr  <= r_fa;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack_i) begin
                        if (br_taken_i) begin
                            // response arrives with the redirect: nothing left in flight
                            r_fa    <= br_target_i;
                            r_drop  <= 1'b0;
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_drop) begin
                            // stale response; fa already points at the target
                            r_drop  <= 1'b0;
                            r_req   <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_fa <= r_fa + 16'd1;
                            if (w_space) begin
                                r_addr <= r_fa + 16'd1;
                            end else begin
                                r_req   <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end else if (br_taken_i) begin
                        r_fa   <= br_target_i;
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (br_taken_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_cnt_next;
        end
    end

    // FIFO storage holds {pc, instruction}; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {r_addr, imem_data_i};
    end

    // Output register toward decode: redirect flushes, stall holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst  <= NOP_INST;
            r_pc    <= 16'h0000;
            r_valid <= 1'b0;
        end else if (br_taken_i) begin
            r_inst  <= NOP_INST;
            r_pc    <= 16'h0000;
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            if (r_count != '0) begin
                r_inst  <= r_mem[r_rptr][31:0];
                r_pc    <= r_mem[r_rptr][47:32];
                r_valid <= 1'b1;
            end else begin
                r_inst  <= NOP_INST;
                r_pc    <= 16'h0000;
                r_valid <= 1'b0;
            end
        end
    end

    assign imem_req_o  = r_req;
    assign imem_addr_o = r_addr;
    assign inst_o      = r_inst;
    assign pc_value_o  = r_pc;
    assign valid_o     = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory answers with 32'h1000_0000 + addr
// whenever auto_ack is set and a request is visible.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h3C00_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        br_taken_i;
    logic [15:0] br_target_i;
    logic        stall_i;
    logic [31:0] inst_o;
    logic [15:0] pc_value_o;
    logic        valid_o;

    int checks;
    int failures;
    logic auto_ack;

    fetch_unit #(.DEPTH(2), .RESET_PC(16'h0000), .NOP_INST(32'h3C00_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .stall_i     (stall_i),
        .inst_o      (inst_o),
        .pc_value_o  (pc_value_o),
        .valid_o     (valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        imem_ack_i  = auto_ack & imem_req_o;
        imem_data_i = 32'h1000_0000 + {16'h0000, imem_addr_o};
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] pc);
        check_val({tag, "_valid"}, 32'(valid_o), 32'(v));
        check_val({tag, "_pc"}, 32'(pc_value_o), 32'(pc));
        check_val({tag, "_inst"}, inst_o, v ? (32'h1000_0000 + {16'h0000, pc}) : NOP);
    endtask

    task automatic check_req(input string tag, input logic r, input logic [15:0] a);
        check_val({tag, "_req"}, 32'(imem_req_o), 32'(r));
        if (r) check_val({tag, "_addr"}, 32'(imem_addr_o), 32'(a));
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        auto_ack    = 1'b0;
        rst         = 1'b0;
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        br_taken_i  = 1'b0;
        br_target_i = '0;
        stall_i     = 1'b0;

        // reset values
        #12;
        check_val("rst_req", 32'(imem_req_o), 32'd0);
        check_val("rst_addr", 32'(imem_addr_o), 32'd0);
        check_out("rst", 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // streaming, memory acks immediately
        auto_ack = 1'b1;
        tick();
        check_req("t1", 1'b1, 16'd0);
        check_out("t1", 1'b0, 16'h0000);
        tick();
        check_req("t2", 1'b1, 16'd1);
        check_out("t2", 1'b0, 16'h0000);
        for (int k = 3; k <= 6; k++) begin
            tick();
            check_out("stream", 1'b1, 16'(k - 3));
            check_req("stream", 1'b1, 16'(k - 1));
        end

        // stall for 5 cycles: one more ack fills the FIFO, then request idles
        stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out("stall", 1'b1, 16'd3);
            check_val("stall_req", 32'(imem_req_o), 32'd0);
        end
        stall_i = 1'b0;
        tick();
        check_out("unstall0", 1'b1, 16'd4);
        check_req("unstall0", 1'b1, 16'd6);
        tick();
        check_out("unstall1", 1'b1, 16'd5);
        check_req("unstall1", 1'b1, 16'd7);
        tick();
        check_out("unstall2", 1'b1, 16'd6);

        // ack delayed 3 cycles on request to 8
        auto_ack = 1'b0;
        tick();
        check_out("dly0", 1'b1, 16'd7);
        check_req("dly0", 1'b1, 16'd8);
        tick();
        check_out("dly1", 1'b0, 16'h0000);
        check_req("dly1", 1'b1, 16'd8);
        tick();
        check_out("dly2", 1'b0, 16'h0000);
        check_req("dly2", 1'b1, 16'd8);
        auto_ack = 1'b1;
        tick();
        check_out("dly3", 1'b0, 16'h0000);
        check_req("dly3", 1'b1, 16'd9);
        tick();
        check_out("dly4", 1'b1, 16'd8);
        check_req("dly4", 1'b1, 16'd10);

        // redirect to 0x0040 while request to 0x000A pending; ack 2 cycles later
        auto_ack    = 1'b0;
        br_taken_i  = 1'b1;
        br_target_i = 16'h0040;
        tick();
        br_taken_i  = 1'b0;
        check_out("brw0", 1'b0, 16'h0000);
        check_req("brw0", 1'b1, 16'h000A);
        tick();
        check_out("brw1", 1'b0, 16'h0000);
        check_req("brw1", 1'b1, 16'h000A);
        auto_ack = 1'b1;
        tick();
        check_out("brw2", 1'b0, 16'h0000);
        check_val("brw2_req", 32'(imem_req_o), 32'd0);
        tick();
        check_out("brw3", 1'b0, 16'h0000);
        check_req("brw3", 1'b1, 16'h0040);
        tick();
        check_out("brw4", 1'b0, 16'h0000);
        check_req("brw4", 1'b1, 16'h0041);
        tick();
        check_out("brw5", 1'b1, 16'h0040);

        // redirect coinciding with ack of 0x0042
        br_taken_i  = 1'b1;
        br_target_i = 16'h0080;
        tick();
        br_taken_i  = 1'b0;
        check_out("brack0", 1'b0, 16'h0000);
        check_val("brack0_req", 32'(imem_req_o), 32'd0);
        tick();
        check_req("brack1", 1'b1, 16'h0080);
        tick();
        tick();
        check_out("brack3", 1'b1, 16'h0080);

        // redirect while stalled, also coinciding with ack
        br_taken_i  = 1'b1;
        br_target_i = 16'h00C0;
        stall_i     = 1'b1;
        tick();
        br_taken_i = 1'b0;
        stall_i    = 1'b0;
        check_out("brstl0", 1'b0, 16'h0000);
        check_val("brstl0_req", 32'(imem_req_o), 32'd0);
        tick();
        check_req("brstl1", 1'b1, 16'h00C0);
        tick();
        tick();
        check_out("brstl3", 1'b1, 16'h00C0);

        // address wrap from 0xFFFE
        br_taken_i  = 1'b1;
        br_target_i = 16'hFFFE;
        tick();
        br_taken_i = 1'b0;
        tick();
        check_req("wrap0", 1'b1, 16'hFFFE);
        tick();
        check_req("wrap1", 1'b1, 16'hFFFF);
        tick();
        check_req("wrap2", 1'b1, 16'h0000);
        check_out("wrap2", 1'b1, 16'hFFFE);
        tick();
        check_out("wrap3", 1'b1, 16'hFFFF);
        tick();
        check_out("wrap4", 1'b1, 16'h0000);

        // asynchronous reset while a request is held
        auto_ack = 1'b0;
        tick();
        check_req("prerst", 1'b1, 16'd2);
        check_out("prerst", 1'b1, 16'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_req", 32'(imem_req_o), 32'd0);
        check_val("arst_addr", 32'(imem_addr_o), 32'd0);
        check_out("arst", 1'b0, 16'h0000);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        auto_ack = 1'b1;
        tick();
        check_req("rerun", 1'b1, 16'd0);
        check_out("rerun", 1'b0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
